dm_responder: RTL
=================

Name: dm_responder

Overview:
Memory-side responder for the CPU's load/store port. It accepts one word request at a time through a valid/ready handshake and inserts a programmable number of wait states. It performs byte-enabled writes or word reads on an internal word array, then returns a single-cycle response carrying read data and an error flag. It replaces the zero-latency data memory so the pipeline's stall logic can be exercised against a memory with real latency.

Parameters:
ADDR_W, 10, word-address width; the array holds 2**ADDR_W 32-bit words.
WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present; held until accepted.
req_ready  output  1  responder can accept a request this cycle.
req_write  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
req_be  input  4  byte enables; bit i covers bits [8i+7:8i].
resp_valid  output  1  one-cycle pulse; response fields are valid.
resp_rdata  output  32  load data; 0 for stores and for errors.
resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (reset==0, async): state goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. The array is not cleared.
- Reset asserted mid-transaction: the transaction is dropped, with no response. A store still waiting in WAIT is not written.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. When req_valid=1, the request is accepted. The responder latches write, addr, wdata and be, and loads counter=WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: req_ready=0. The counter decrements each cycle; when it reaches 1, next state is RESP.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle. Next state is IDLE.
- There is no back-to-back accept in RESP. The minimum request spacing is WAIT_CYCLES+2 cycles.
- Latency: resp_valid is asserted exactly WAIT_CYCLES+1 cycles after the accepting edge.
- Error check, on the latched request:
  - Misaligned if addr[1:0]!=0.
  - Out of range if (addr-BASE_ADDR)>>2 >= 2**ADDR_W, or addr<BASE_ADDR.
  - On error: no array write, resp_err=1, resp_rdata=0.
- Store: performed on the clock edge that enters RESP. Only the lanes with be[i]=1 are updated; be=0 is a legal no-op that still responds. resp_rdata=0.
- Load: resp_rdata is the array word at the latched index, registered on entry to RESP; req_be is ignored. A load following a store to the same word returns the stored data.
- resp_rdata and resp_err hold their values until the next response and are meaningful only while resp_valid=1. They return to 0 only on reset.
- Request inputs are sampled only at acceptance. Changes while busy have no effect.

Decomposition:
- Shared package dm_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - word-lane constant (4 bytes);
  - error reason constants (misaligned, out-of-range), for debug only.
- Sub-module dm_array:
  - 2**ADDR_W x 32 storage;
  - synchronous byte-enabled write;
  - combinational read at index.
- dm_responder contains the FSM, wait counter, address decode and response registers.

Test Plan:
- Reset check: reset low mid-WAIT of a store to 0x10 (WAIT_CYCLES=2), then release and load 0x10. Required: no response for the aborted store; the load returns the pre-reset value; req_ready=1 immediately after reset.
- Store/load latency: store 0xDEADBEEF, be=4'hF, to 0x40 with WAIT_CYCLES=2, then load 0x40. Required: each resp_valid is a single cycle exactly 3 cycles after its accept; the load returns 0xDEADBEEF with resp_err=0.
- Byte enables: store 0x11223344 to 0x80 with be=4'hF, then store 0xAABBCCDD with be=4'b0101, then load 0x80. Required: the load returns 0x11BB33DD.
- Errors: load 0x42 (misaligned), then store to byte offset 4*2**ADDR_W. Required: resp_err=1 and resp_rdata=0 for both; a following load of word 0 is unchanged.
- Zero wait states (WAIT_CYCLES=0): hold req_valid high continuously with alternating store/load. Required: resp_valid 1 cycle after each accept; req_ready low in the RESP cycle; accepts every 2 cycles.
- Input stability: change req_addr and req_wdata while in WAIT. Required: the response reflects the latched request values only.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane count
// and error-reason bit positions.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  localparam int LANES = 4;

  // Bit positions inside the error-reason vector; only their OR leaves the block.
  localparam int ERR_MISALIGNED = 0;
  localparam int ERR_RANGE      = 1;
  localparam int ERR_W          = 2;

endpackage

// File: rtl/dm_array.sv
// Word-organised storage with byte-lane write enables and a combinational read port.
// Contents are deliberately not reset.
module dm_array
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] index,
  input  logic [31:0]       wdata,
  input  logic [LANES-1:0]  be,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dm_responder.sv
// Load/store responder with programmable wait states in front of dm_array.
// One request in flight at a time; the response is a single-cycle pulse.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dm_state_t         state, next_state;
  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic [31:0]       lat_addr, lat_wdata;
  logic [3:0]        lat_be;
  logic              cur_write;
  logic [31:0]       cur_addr, cur_wdata, offset;
  logic [3:0]        cur_be;
  logic [ERR_W-1:0]  err_reason;
  logic              enter_resp, array_we;
  logic [ADDR_W-1:0] index;
  logic [31:0]       array_rdata;
  logic [31:0]       rdata_q;
  logic              err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            wait_cnt  <= WAIT_INIT;
          end
        end
        WAIT:    wait_cnt <= wait_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (wait_cnt <= 4'd1) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accepting edge, before the
  // latches hold the request, so decode from the live inputs in that case.
  assign cur_write = (state == IDLE) ? req_write : lat_write;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign cur_be    = (state == IDLE) ? req_be    : lat_be;

  assign offset = cur_addr - BASE_ADDR;
  assign index  = offset[ADDR_W+1:2];

  always_comb begin
    err_reason                 = '0;
    err_reason[ERR_MISALIGNED] = (cur_addr[1:0] != 2'b00);
    err_reason[ERR_RANGE]      = (cur_addr < BASE_ADDR) || ((offset >> (ADDR_W + 2)) != 32'd0);
  end

  assign enter_resp = (next_state == RESP) && (state != RESP);
  assign array_we   = enter_resp && cur_write && (err_reason == '0);

  dm_array #(.ADDR_W(ADDR_W)) u_array (
    .clock (clock),
    .we    (array_we),
    .index (index),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (array_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= |err_reason;
      rdata_q <= (cur_write || (|err_reason)) ? 32'd0 : array_rdata;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
